// File: rtl/params.sv
// ============================================================================
//  params : shared constants for the modulation datapath
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package params;
  localparam int         NumSegment               = 2;
  localparam logic [7:0] TRANSITION_MODE_SYNC_IDX = 8'h00;
endpackage

`default_nettype wire

// File: rtl/modulation_transition_sequencer.sv
// ============================================================================
//  modulation_transition_sequencer : queues host segment-transition requests
//  and issues them one at a time to the modulation swapchain.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module modulation_transition_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                                 CLK,
  input  logic                                 RST_N,
  input  logic                                 REQ_VALID,
  output logic                                 REQ_READY,
  input  logic                                 REQ_SEGMENT,
  input  logic [7:0]                           REQ_MODE,
  input  logic [63:0]                          REQ_VALUE,
  input  logic [31:0]                          REQ_REP,
  input  logic                                 ABORT,
  input  logic                                 SEGMENT,
  input  logic                                 STOP,
  output logic                                 UPDATE_SETTINGS,
  output logic                                 REQ_RD_SEGMENT,
  output logic [7:0]                           TRANSITION_MODE,
  output logic [63:0]                          TRANSITION_VALUE,
  output logic [32*params::NumSegment-1:0]     REP,
  output logic                                 BUSY,
  output logic                                 OVERFLOW,
  output logic [15:0]                          DONE_CNT
);

  localparam int                NSEG       = params::NumSegment;
  localparam int                PTR_W      = $clog2(DEPTH);
  localparam int                CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [31:0]       REP_INF    = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        seg;
    logic [7:0]  mode;
    logic [63:0] value;
    logic [31:0] rep;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_SWAP = 2'd2,
    ST_WAIT_STOP = 2'd3
  } state_t;

  state_t                state_q, state_d;
  entry_t                fifo_mem_q [DEPTH];
  entry_t                fifo_mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  update_q, update_d;
  logic                  rd_segment_q, rd_segment_d;
  logic [7:0]            mode_q, mode_d;
  logic [63:0]           value_q, value_d;
  logic [32*NSEG-1:0]    rep_q, rep_d;
  logic                  infinite_q, infinite_d;
  logic                  overflow_q, overflow_d;
  logic [15:0]           done_cnt_q, done_cnt_d;

  entry_t                head;
  logic                  push;
  logic                  pop;
  logic                  complete;

  always_comb begin
    state_d      = state_q;
    fifo_mem_d   = fifo_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    update_d     = 1'b0;
    rd_segment_d = rd_segment_q;
    mode_d       = mode_q;
    value_d      = value_q;
    rep_d        = rep_q;
    infinite_d   = infinite_q;
    overflow_d   = overflow_q;
    done_cnt_d   = done_cnt_q;
    head         = fifo_mem_q[rd_ptr_q];
    pop          = 1'b0;
    complete     = 1'b0;
    push         = REQ_VALID && (count_q != FULL_COUNT);

    if (REQ_VALID && (count_q == FULL_COUNT)) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop          = 1'b1;
          rd_segment_d = head.seg;
          mode_d       = head.mode;
          value_d      = head.value;
          infinite_d   = (head.rep == REP_INF);
          for (int s = 0; s < NSEG; s++) begin
            if (32'(head.seg) == s) begin
              rep_d[s*32 +: 32] = head.rep;
            end
          end
          update_d = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (SEGMENT == rd_segment_q) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_WAIT_SWAP;
        end
      end
      // STOP must read low here so a stale stop from the old segment is ignored.
      ST_WAIT_SWAP: begin
        if ((SEGMENT == rd_segment_q) && !STOP) begin
          if (infinite_q) begin
            complete = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d  = ST_WAIT_STOP;
          end
        end
      end
      ST_WAIT_STOP: begin
        if (STOP) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (push) begin
      fifo_mem_d[wr_ptr_q] = {REQ_SEGMENT, REQ_MODE, REQ_VALUE, REQ_REP};
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (complete) begin
      done_cnt_d = done_cnt_q + 16'd1;
    end

    // Abort flushes control state but leaves everything the swapchain sees alone.
    if (ABORT) begin
      state_d      = ST_IDLE;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      update_d     = 1'b0;
      overflow_d   = 1'b0;
      rd_segment_d = rd_segment_q;
      mode_d       = mode_q;
      value_d      = value_q;
      rep_d        = rep_q;
      infinite_d   = infinite_q;
      done_cnt_d   = done_cnt_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      update_q     <= 1'b0;
      rd_segment_q <= 1'b0;
      mode_q       <= params::TRANSITION_MODE_SYNC_IDX;
      value_q      <= '0;
      rep_q        <= {NSEG{REP_INF}};
      infinite_q   <= 1'b1;
      overflow_q   <= 1'b0;
      done_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      update_q     <= update_d;
      rd_segment_q <= rd_segment_d;
      mode_q       <= mode_d;
      value_q      <= value_d;
      rep_q        <= rep_d;
      infinite_q   <= infinite_d;
      overflow_q   <= overflow_d;
      done_cnt_q   <= done_cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    fifo_mem_q <= fifo_mem_d;
  end

  assign REQ_READY        = (count_q != FULL_COUNT);
  assign BUSY             = (state_q != ST_IDLE) || (count_q != '0);
  assign UPDATE_SETTINGS  = update_q;
  assign REQ_RD_SEGMENT   = rd_segment_q;
  assign TRANSITION_MODE  = mode_q;
  assign TRANSITION_VALUE = value_q;
  assign REP              = rep_q;
  assign OVERFLOW         = overflow_q;
  assign DONE_CNT         = done_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_modulation_transition_sequencer.sv
// ============================================================================
//  tb_modulation_transition_sequencer : directed self-checking bench
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_modulation_transition_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_segment;
  logic [7:0]  req_mode;
  logic [63:0] req_value;
  logic [31:0] req_rep;
  logic        abort;
  logic        segment;
  logic        stop;
  logic        update_settings;
  logic        req_rd_segment;
  logic [7:0]  transition_mode;
  logic [63:0] transition_value;
  logic [63:0] rep;
  logic        busy;
  logic        overflow;
  logic [15:0] done_cnt;

  int tests    = 0;
  int fails    = 0;
  int strobes  = 0;
  logic prev_upd = 1'b0;
  logic consec   = 1'b0;

  modulation_transition_sequencer #(.DEPTH(4)) dut (
    .CLK              (clk),
    .RST_N            (rst_n),
    .REQ_VALID        (req_valid),
    .REQ_READY        (req_ready),
    .REQ_SEGMENT      (req_segment),
    .REQ_MODE         (req_mode),
    .REQ_VALUE        (req_value),
    .REQ_REP          (req_rep),
    .ABORT            (abort),
    .SEGMENT          (segment),
    .STOP             (stop),
    .UPDATE_SETTINGS  (update_settings),
    .REQ_RD_SEGMENT   (req_rd_segment),
    .TRANSITION_MODE  (transition_mode),
    .TRANSITION_VALUE (transition_value),
    .REP              (rep),
    .BUSY             (busy),
    .OVERFLOW         (overflow),
    .DONE_CNT         (done_cnt)
  );

  always #5 clk = ~clk;

  // Strobe monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (update_settings) begin
      strobes = strobes + 1;
      if (prev_upd) consec = 1'b1;
    end
    prev_upd = update_settings;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic seg, input logic [7:0] mode, input logic [63:0] val,
                      input logic [31:0] r);
    req_valid   = 1'b1;
    req_segment = seg;
    req_mode    = mode;
    req_value   = val;
    req_rep     = r;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_segment = 1'b0; req_mode = 8'h00;
    req_value = 64'd0; req_rep = 32'd0; abort = 1'b0; segment = 1'b0; stop = 1'b0;

    // Reset
    step(3);
    chk("rst_update",  update_settings, 1'b0);
    chk("rst_rdseg",   req_rd_segment, 1'b0);
    chk("rst_mode",    transition_mode, 8'h00);
    chk("rst_value",   transition_value, 64'd0);
    chk("rst_rep",     rep, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_ovf",     overflow, 1'b0);
    chk("rst_done",    done_cnt, 16'd0);
    chk("rst_ready",   req_ready, 1'b1);
    chk("rst_busy",    busy, 1'b0);
    rst_n = 1'b1;
    step(1);

    // Infinite request, seg 1 while swapchain on seg 0
    strobes = 0;
    push(1'b1, 8'h01, 64'h1234_5678_9ABC_DEF0, 32'hFFFF_FFFF);
    step(1);
    req_valid = 1'b0;
    chk("inf_c1_update", update_settings, 1'b0);
    chk("inf_c1_busy",   busy, 1'b1);
    step(1);
    chk("inf_c2_update", update_settings, 1'b1);
    chk("inf_c2_rdseg",  req_rd_segment, 1'b1);
    chk("inf_c2_mode",   transition_mode, 8'h01);
    chk("inf_c2_value",  transition_value, 64'h1234_5678_9ABC_DEF0);
    chk("inf_c2_rep",    rep, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1);
    chk("inf_c3_update", update_settings, 1'b0);
    segment = 1'b1;
    step(1);
    chk("inf_done",      done_cnt, 16'd1);
    chk("inf_busy",      busy, 1'b0);
    chk("inf_strobes",   strobes, 1);

    // Finite request then queued infinite request
    segment = 1'b0; stop = 1'b0; strobes = 0;
    push(1'b1, 8'h02, 64'd5, 32'd3);
    step(1);
    push(1'b0, 8'h00, 64'd7, 32'hFFFF_FFFF);
    step(1);
    req_valid = 1'b0;
    chk("fin_update",    update_settings, 1'b1);
    chk("fin_rdseg",     req_rd_segment, 1'b1);
    chk("fin_rep",       rep, {32'd3, 32'hFFFF_FFFF});
    step(10);
    chk("fin_wait_busy", busy, 1'b1);
    chk("fin_wait_strb", strobes, 1);
    segment = 1'b1;
    step(20);
    chk("fin_stop_strb", strobes, 1);
    chk("fin_stop_done", done_cnt, 16'd1);
    stop = 1'b1;
    step(2);
    chk("q2_done",       done_cnt, 16'd2);
    chk("q2_update",     update_settings, 1'b1);
    chk("q2_rdseg",      req_rd_segment, 1'b0);
    chk("q2_value",      transition_value, 64'd7);
    chk("q2_rep",        rep, {32'd3, 32'hFFFF_FFFF});
    segment = 1'b0; stop = 1'b0;
    step(1);
    chk("q2_done_after", done_cnt, 16'd3);
    chk("q2_busy",       busy, 1'b0);
    chk("q2_strobes",    strobes, 2);

    // Same segment: completes straight out of ISSUE
    strobes = 0;
    push(1'b0, 8'h01, 64'd9, 32'd5);
    step(1);
    req_valid = 1'b0;
    step(1);
    chk("same_update",   update_settings, 1'b1);
    chk("same_rep",      rep, {32'd3, 32'd5});
    step(1);
    chk("same_upd_off",  update_settings, 1'b0);
    chk("same_busy",     busy, 1'b0);
    chk("same_done",     done_cnt, 16'd4);
    chk("same_strobes",  strobes, 1);

    // Full / overflow with a stalled swapchain, then abort
    strobes = 0;
    for (int i = 0; i < 6; i++) begin
      push(1'b1, 8'h00, 64'd0, 32'(10 + i));
      chk($sformatf("full_ready_%0d", i), req_ready, (i < 5) ? 1'b1 : 1'b0);
      step(1);
    end
    req_valid = 1'b0;
    chk("ovf_set",       overflow, 1'b1);
    chk("ovf_ready",     req_ready, 1'b0);
    chk("ovf_busy",      busy, 1'b1);
    abort = 1'b1;
    req_valid = 1'b1;
    step(1);
    abort = 1'b0; req_valid = 1'b0;
    chk("abort_ovf",     overflow, 1'b0);
    chk("abort_ready",   req_ready, 1'b1);
    chk("abort_busy",    busy, 1'b0);
    step(5);
    chk("abort_strobes", strobes, 1);
    chk("abort_rdseg",   req_rd_segment, 1'b1);
    chk("abort_rep",     rep, {32'd10, 32'd5});
    chk("abort_done",    done_cnt, 16'd4);

    // Reset while waiting on STOP, with another request queued
    segment = 1'b0; stop = 1'b0;
    push(1'b1, 8'h02, 64'd1, 32'd4);
    step(1);
    push(1'b0, 8'h02, 64'd2, 32'd6);
    step(1);
    req_valid = 1'b0;
    step(1);
    segment = 1'b1;
    step(3);
    chk("mid_busy",      busy, 1'b1);
    chk("mid_rep",       rep, {32'd4, 32'd5});
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("mr_update",     update_settings, 1'b0);
    chk("mr_rep",        rep, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("mr_busy",       busy, 1'b0);
    chk("mr_ready",      req_ready, 1'b1);
    chk("mr_done",       done_cnt, 16'd0);
    chk("mr_mode",       transition_mode, 8'h00);
    strobes = 0;
    stop = 1'b1;
    step(4);
    chk("mr_strobes",    strobes, 0);
    chk("mr_done_after", done_cnt, 16'd0);
    chk("no_consec",     consec, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
